tdm_scan_mux: RTL and testbench

Parametrised, registered N:1 multiplexer with a built-in channel sequencer. In manual mode it selects the channel given on sel_in. In auto mode it scans the enabled channels round-robin, dwelling a programmable number of cycles on each. It is the sequential successor to the team's combinational wide muxes and is used for time-division readout of multi-channel buses.

---
 rtl/tdm_scan_mux.sv | 140 ++++++++++++++
 tb/tb_tdm_scan_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_scan_mux.sv
// rtl/tdm_scan_mux.sv - registered N:1 mux with manual select and round-robin auto scan
// Channel i occupies in[i*DATA_W +: DATA_W]; cur_sel leads out by one cycle while scanning.
module tdm_scan_mux #(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4,
  parameter int DWELL  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] in,
  output logic [DATA_W-1:0]        out,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     frame_done
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  dwell_cnt;
  logic [DATA_W-1:0] ch [NUM_CH];

  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] cur_data;
  logic              sel_ok;
  logic              cur_en;
  logic              any_en;
  logic              wrap;
  logic [SEL_W-1:0]  lowest;
  logic [SEL_W-1:0]  next_sel;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch[g] = in[g*DATA_W +: DATA_W];
  end

  assign any_en = |ch_mask;

  // Descending walk so the lowest qualifying index wins; indices >= NUM_CH never match.
  always_comb begin
    sel_data = '0;
    cur_data = '0;
    sel_ok   = 1'b0;
    cur_en   = 1'b0;
    lowest   = '0;
    next_sel = '0;
    wrap     = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sel_in == SEL_W'(i)) begin
        sel_data = ch[i];
        sel_ok   = 1'b1;
      end
      if (cur_sel == SEL_W'(i)) begin
        cur_data = ch[i];
        cur_en   = ch_mask[i];
      end
      if (ch_mask[i]) begin
        lowest = SEL_W'(i);
        if (SEL_W'(i) > cur_sel) begin
          next_sel = SEL_W'(i);
          wrap     = 1'b0;
        end
      end
    end
    if (wrap) next_sel = lowest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dwell_cnt  <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      cur_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          SCAN: begin
            if (!mode) begin
              state     <= MANUAL;
              out_valid <= 1'b0;
              dwell_cnt <= '0;
            end else begin
              out <= cur_data;
              if (!any_en) begin
                out_valid <= 1'b0;
                dwell_cnt <= '0;
              end else if (!cur_en || dwell_cnt == DWELL_LAST) begin
                // a dropped channel is abandoned at once, ending its dwell early
                out_valid  <= cur_en;
                dwell_cnt  <= '0;
                cur_sel    <= next_sel;
                frame_done <= wrap;
              end else begin
                out_valid <= 1'b1;
                dwell_cnt <= dwell_cnt + 1'b1;
              end
            end
          end
          MANUAL: begin
            if (mode) begin
              state     <= SCAN;
              out_valid <= 1'b0;
              dwell_cnt <= '0;
              if (any_en) cur_sel <= lowest;
            end else begin
              cur_sel   <= sel_in;
              out       <= sel_data;
              out_valid <= sel_ok;
            end
          end
          default: begin
            out_valid <= 1'b0;
            dwell_cnt <= '0;
            if (mode) begin
              state <= SCAN;
              if (any_en) cur_sel <= lowest;
            end else begin
              state <= MANUAL;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_scan_mux.sv
// tb/tb_tdm_scan_mux.sv - directed and randomized check of tdm_scan_mux against a behavioural model
module tb_tdm_scan_mux;

  localparam int DATA_W = 3;
  localparam int NUM_CH = 12;
  localparam int SEL_W  = 4;
  localparam int DWELL  = 2;
  localparam int IN_W   = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              mode = 1'b0;
  logic [SEL_W-1:0]  sel_in = '0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [IN_W-1:0]   in_bus = '0;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic [SEL_W-1:0]  cur_sel;
  logic              frame_done;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  tdm_scan_mux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .ch_mask(ch_mask),
    .in(in_bus), .out(out), .out_valid(out_valid), .cur_sel(cur_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model state: 0 idle, 1 manual, 2 scan; m_dw counts cycles already spent on m_cur.
  int m_st = 0;
  int m_cur = 0;
  int m_dw = 0;
  int m_out = 0;
  bit m_v = 1'b0;
  bit m_fd = 1'b0;

  function automatic int chan(input logic [IN_W-1:0] bus, input int i);
    logic [IN_W-1:0] sh;
    if (i >= NUM_CH) return 0;
    sh = bus >> (i * DATA_W);
    return int'(sh[DATA_W-1:0]);
  endfunction

  function automatic int next_on(input int cur, input logic [NUM_CH-1:0] m);
    if (cur >= NUM_CH) begin
      for (int j = 0; j < NUM_CH; j++) if (m[j]) return j;
      return -1;
    end
    for (int k = 1; k <= NUM_CH; k++) begin
      int j;
      j = (cur + k) % NUM_CH;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nx;
    if (!rst_n) begin
      m_st = 0; m_cur = 0; m_dw = 0; m_out = 0; m_v = 1'b0; m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (!en) begin
        m_st = 0; m_v = 1'b0; m_dw = 0;
      end else if (m_st == 0 || (m_st == 1 && mode)) begin
        m_v = 1'b0; m_dw = 0;
        if (mode) begin
          m_st = 2;
          nx = next_on(NUM_CH, ch_mask);
          if (nx >= 0) m_cur = nx;
        end else begin
          m_st = 1;
        end
      end else if (m_st == 2 && !mode) begin
        m_st = 1; m_v = 1'b0; m_dw = 0;
      end else if (m_st == 1) begin
        m_cur = int'(sel_in);
        m_v   = (int'(sel_in) < NUM_CH);
        m_out = chan(in_bus, m_cur);
      end else begin
        m_out = chan(in_bus, m_cur);
        nx = next_on(m_cur, ch_mask);
        if (nx < 0) begin
          m_v = 1'b0; m_dw = 0;
        end else if (m_cur >= NUM_CH || !ch_mask[m_cur]) begin
          m_v = 1'b0; m_dw = 0; m_fd = (nx <= m_cur); m_cur = nx;
        end else begin
          m_v = 1'b1;
          m_dw++;
          if (m_dw == DWELL) begin
            m_dw = 0; m_fd = (nx <= m_cur); m_cur = nx;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp++;
      if (out !== DATA_W'(m_out) || out_valid !== m_v || cur_sel !== SEL_W'(m_cur) || frame_done !== m_fd) begin
        n_fail++;
        $display("FAIL model t=%0t got out=%0d valid=%0b cur_sel=%0d frame_done=%0b exp out=%0d valid=%0b cur_sel=%0d frame_done=%0b",
                 $time, out, out_valid, cur_sel, frame_done, m_out, m_v, m_cur, m_fd);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_all0(input string name);
    check({name, "_out"}, 32'(out), 0);
    check({name, "_valid"}, 32'(out_valid), 0);
    check({name, "_cur"}, 32'(cur_sel), 0);
    check({name, "_fd"}, 32'(frame_done), 0);
  endtask

  int sels[4]    = '{2, 5, 6, 9};
  int exp_cur[7] = '{0, 2, 2, 5, 5, 0, 0};
  int exp_out[7] = '{1, 1, 3, 3, 6, 6, 1};
  int exp_fd[7]  = '{0, 0, 0, 0, 0, 1, 0};
  int exp_fd4[4] = '{0, 1, 0, 1};

  initial begin
    // channel i carries (i+1) mod 8
    for (int i = 0; i < NUM_CH; i++) in_bus[i*DATA_W +: DATA_W] = DATA_W'((i + 1) % 8);
    #1 chk_on = 1'b1;
    @(negedge clk);
    check_all0("reset");

    rst_n = 1'b1; en = 1'b1; mode = 1'b0; sel_in = '0;
    @(negedge clk);
    foreach (sels[k]) begin
      sel_in = SEL_W'(sels[k]);
      @(negedge clk);
      check("man_out", 32'(out), 32'((sels[k] + 1) % 8));
      check("man_valid", 32'(out_valid), 1);
      check("man_cur", 32'(cur_sel), 32'(sels[k]));
    end
    sel_in = 4'd15;
    @(negedge clk);
    check("man_oor_out", 32'(out), 0);
    check("man_oor_valid", 32'(out_valid), 0);

    mode = 1'b1; ch_mask = 12'h025;
    @(negedge clk);
    check("scan_entry_cur", 32'(cur_sel), 0);
    check("scan_entry_valid", 32'(out_valid), 0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("scan_cur", 32'(cur_sel), 32'(exp_cur[k]));
      check("scan_out", 32'(out), 32'(exp_out[k]));
      check("scan_fd", 32'(frame_done), 32'(exp_fd[k]));
    end
    @(negedge clk);
    @(negedge clk);
    check("pre_drop_cur", 32'(cur_sel), 2);
    ch_mask = 12'h000;
    @(negedge clk);
    check("zero_valid", 32'(out_valid), 0);
    check("zero_cur", 32'(cur_sel), 2);
    check("zero_fd", 32'(frame_done), 0);
    ch_mask = 12'h020;
    @(negedge clk);
    check("resume_cur", 32'(cur_sel), 5);
    @(negedge clk);
    check("resume_valid", 32'(out_valid), 1);
    check("resume_out", 32'(out), 6);

    mode = 1'b0; sel_in = 4'd15;
    @(negedge clk);
    @(negedge clk);
    check("oor_out", 32'(out), 0);
    check("oor_valid", 32'(out_valid), 0);
    mode = 1'b1; ch_mask = 12'h001;
    @(negedge clk);
    check("single_entry_cur", 32'(cur_sel), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("single_fd", 32'(frame_done), 32'(exp_fd4[k]));
      check("single_cur", 32'(cur_sel), 0);
    end

    ch_mask = 12'h020;
    @(negedge clk);
    check("to5_cur", 32'(cur_sel), 5);
    @(negedge clk);
    check("on5_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 check_all0("async_reset");
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; mode = 1'b1; ch_mask = 12'h025;
    @(negedge clk);
    check("restart_cur", 32'(cur_sel), 0);

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_off_valid", 32'(out_valid), 0);
    check("en_off_out", 32'(out), 1);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reen_cur0", 32'(cur_sel), 0);
    check("reen_valid", 32'(out_valid), 1);
    @(negedge clk);
    check("reen_cur1", 32'(cur_sel), 2);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      in_bus = IN_W'({$urandom(), $urandom()});
      if ($urandom_range(0, 19) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      sel_in = SEL_W'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: ch_mask = '0;
          1: ch_mask = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
          default: ch_mask = NUM_CH'($urandom());
        endcase
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
